fraction_multiplier4_arbiter: RTL and testbench



---
 rtl/fraction_multiplier4_pkg.sv | 25 ++
 rtl/fraction_multiplier4_arbiter_rr_pick.sv | 33 +++
 rtl/fraction_multiplier4_arbiter.sv | 156 +++++++++++++++
 tb/tb_fraction_multiplier4_arbiter.sv | 281 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fraction_multiplier4_pkg.sv
// Shared constants, FSM state codes and width helper for the multiplier arbiter.
package fraction_multiplier4_pkg;

  localparam int unsigned OPW = 4;  // signed fraction operand width
  localparam int unsigned PW  = 7;  // signed fraction product width

  // Arbiter FSM state codes
  localparam logic [2:0] S_SYNC  = 3'd0;
  localparam logic [2:0] S_IDLE  = 3'd1;
  localparam logic [2:0] S_START = 3'd2;
  localparam logic [2:0] S_WAIT  = 3'd3;
  localparam logic [2:0] S_DRAIN = 3'd4;

  // Width able to hold the pointer and both cycle counters
  function automatic int unsigned cnt_width(input int unsigned nreq,
                                            input int unsigned wdog_cycles,
                                            input int unsigned sync_cycles);
    int unsigned m;
    m = nreq;
    if (wdog_cycles + 1 > m) m = wdog_cycles + 1;
    if (sync_cycles + 1 > m) m = sync_cycles + 1;
    return (m < 2) ? 1 : $clog2(m);
  endfunction

endpackage

// File: rtl/fraction_multiplier4_arbiter_rr_pick.sv
// Round-robin picker: first set request at or above ptr, wrapping around.
module rr_pick #(
  parameter int unsigned N  = 4,
  parameter int unsigned IW = 2
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  pick,
  output logic [IW-1:0] idx
);

  int unsigned best;
  int unsigned off;

  // Choose the requester with the smallest rotational distance from ptr
  always_comb begin
    best = N;
    off  = 0;
    idx  = '0;
    pick = '0;
    for (int k = 0; k < N; k++) begin
      off = (32'(k) + N - 32'(ptr)) % N;
      if (req[k] && (off < best)) begin
        best = off;
        idx  = IW'(k);
      end
    end
    for (int k = 0; k < N; k++) begin
      pick[k] = req[k] && (idx == IW'(k));
    end
  end

endmodule

// File: rtl/fraction_multiplier4_arbiter.sv
// Round-robin sharing of one fraction_multiplier4 among NREQ requesters.
module fraction_multiplier4_arbiter
  import fraction_multiplier4_pkg::*;
#(
  parameter int unsigned NREQ        = 4,
  parameter int unsigned WDOG_CYCLES = 15,
  parameter int unsigned SYNC_CYCLES = 8
) (
  input  logic                 CLK,
  input  logic                 RST_N,
  input  logic [NREQ-1:0]      Req,
  input  logic [OPW*NREQ-1:0]  Mplier_in,
  input  logic [OPW*NREQ-1:0]  Mcand_in,
  output logic [NREQ-1:0]      Gnt,
  output logic [NREQ-1:0]      Ack,
  output logic [PW-1:0]        Result,
  output logic                 Err,
  output logic                 Mul_St,
  output logic [OPW-1:0]       Mul_Mplier,
  output logic [OPW-1:0]       Mul_Mcand,
  input  logic [PW-1:0]        Mul_Product,
  input  logic                 Mul_Done
);

  localparam int unsigned CW = cnt_width(NREQ, WDOG_CYCLES, SYNC_CYCLES);

  logic [2:0]      state, state_nxt;
  logic [CW-1:0]   cnt, cnt_nxt;
  logic [CW-1:0]   ptr, ptr_nxt;
  logic [CW-1:0]   gnt_idx, idx_nxt;
  logic [NREQ-1:0] gnt_nxt, ack_nxt;
  logic [PW-1:0]   result_nxt;
  logic            err_nxt, st_nxt;
  logic [OPW-1:0]  mplier_nxt, mcand_nxt;

  logic [NREQ-1:0] pick;
  logic [CW-1:0]   pick_idx;
  logic [OPW-1:0]  sel_mplier, sel_mcand;
  logic [CW-1:0]   ptr_after;

  rr_pick #(.N(NREQ), .IW(CW)) u_rr_pick (
    .req  (Req),
    .ptr  (ptr),
    .pick (pick),
    .idx  (pick_idx)
  );

  // Operand mux for the requester currently picked
  always_comb begin
    sel_mplier = '0;
    sel_mcand  = '0;
    for (int k = 0; k < NREQ; k++) begin
      if (pick[k]) begin
        sel_mplier = Mplier_in[k*OPW +: OPW];
        sel_mcand  = Mcand_in[k*OPW +: OPW];
      end
    end
  end

  assign ptr_after = (gnt_idx == CW'(NREQ - 1)) ? '0 : gnt_idx + CW'(1);

  // State, pointer, counters and all outputs
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state      <= S_SYNC;
      cnt        <= '0;
      ptr        <= '0;
      gnt_idx    <= '0;
      Gnt        <= '0;
      Ack        <= '0;
      Result     <= '0;
      Err        <= 1'b0;
      Mul_St     <= 1'b0;
      Mul_Mplier <= '0;
      Mul_Mcand  <= '0;
    end else begin
      state      <= state_nxt;
      cnt        <= cnt_nxt;
      ptr        <= ptr_nxt;
      gnt_idx    <= idx_nxt;
      Gnt        <= gnt_nxt;
      Ack        <= ack_nxt;
      Result     <= result_nxt;
      Err        <= err_nxt;
      Mul_St     <= st_nxt;
      Mul_Mplier <= mplier_nxt;
      Mul_Mcand  <= mcand_nxt;
    end
  end

  // Next state and next registered outputs
  always_comb begin
    state_nxt  = state;
    cnt_nxt    = cnt;
    ptr_nxt    = ptr;
    idx_nxt    = gnt_idx;
    gnt_nxt    = Gnt;
    ack_nxt    = '0;
    result_nxt = Result;
    err_nxt    = 1'b0;
    st_nxt     = 1'b0;
    mplier_nxt = Mul_Mplier;
    mcand_nxt  = Mul_Mcand;
    case (state)
      // Let a multiplier that survived reset finish before issuing St
      S_SYNC: begin
        if (cnt == CW'(SYNC_CYCLES - 1)) begin
          state_nxt = S_IDLE;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt + CW'(1);
        end
      end
      S_IDLE: begin
        if (Req != '0) begin
          state_nxt  = S_START;
          gnt_nxt    = pick;
          idx_nxt    = pick_idx;
          mplier_nxt = sel_mplier;
          mcand_nxt  = sel_mcand;
        end
      end
      S_START: begin
        st_nxt    = 1'b1;
        cnt_nxt   = '0;
        state_nxt = S_WAIT;
      end
      S_WAIT: begin
        cnt_nxt = cnt + CW'(1);
        if (Mul_Done) begin
          result_nxt = Mul_Product;
          ack_nxt    = Gnt;
          gnt_nxt    = '0;
          ptr_nxt    = ptr_after;
          state_nxt  = S_DRAIN;
        end else if (cnt == CW'(WDOG_CYCLES)) begin
          result_nxt = '0;
          ack_nxt    = Gnt;
          err_nxt    = 1'b1;
          gnt_nxt    = '0;
          ptr_nxt    = ptr_after;
          state_nxt  = S_DRAIN;
        end
      end
      // Hold off until Done drops so it cannot complete the next job
      S_DRAIN: begin
        if (!Mul_Done) state_nxt = S_IDLE;
      end
      default: begin
        state_nxt = S_SYNC;
        cnt_nxt   = '0;
      end
    endcase
  end

endmodule

// File: tb/tb_fraction_multiplier4_arbiter.sv
// Directed bench for fraction_multiplier4_arbiter with a stub multiplier and a cycle model.
module tb_fraction_multiplier4_arbiter;

  localparam int unsigned NREQ = 4;
  localparam int unsigned WDOG = 15;
  localparam int unsigned SYNC = 8;

  logic            CLK = 1'b0;
  logic            RST_N;
  logic [NREQ-1:0] Req;
  logic [4*NREQ-1:0] Mplier_in, Mcand_in;
  logic [NREQ-1:0] Gnt, Ack;
  logic [6:0]      Result;
  logic            Err, Mul_St;
  logic [3:0]      Mul_Mplier, Mul_Mcand;
  logic [6:0]      Mul_Product = 7'd0;
  logic            Mul_Done = 1'b0;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  fraction_multiplier4_arbiter #(.NREQ(NREQ), .WDOG_CYCLES(WDOG), .SYNC_CYCLES(SYNC)) dut (
    .CLK(CLK), .RST_N(RST_N), .Req(Req), .Mplier_in(Mplier_in), .Mcand_in(Mcand_in),
    .Gnt(Gnt), .Ack(Ack), .Result(Result), .Err(Err), .Mul_St(Mul_St),
    .Mul_Mplier(Mul_Mplier), .Mul_Mcand(Mul_Mcand),
    .Mul_Product(Mul_Product), .Mul_Done(Mul_Done)
  );

  initial forever #5 CLK = ~CLK;

  initial begin
    #100000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s (cycle %0d): got 0x%0h, expected 0x%0h", nm, cyc, act, exp);
    end
  endtask

  // Stub multiplier: Done after stub_lat cycles for stub_len cycles, or never
  int stub_lat = 2;
  int stub_len = 1;
  bit stub_never = 1'b0;
  int s_cnt = 0;
  int s_left = 0;
  int prod;
  always @(posedge CLK) begin
    if (Mul_St && !stub_never) begin
      s_cnt <= stub_lat;
    end else if (s_cnt > 0) begin
      s_cnt <= s_cnt - 1;
      if (s_cnt == 1) begin
        prod = $signed(Mul_Mplier) * $signed(Mul_Mcand);
        Mul_Product <= 7'(prod);
        Mul_Done    <= 1'b1;
        s_left      <= stub_len;
      end
    end else if (Mul_Done) begin
      if (s_left <= 1) Mul_Done <= 1'b0;
      s_left <= s_left - 1;
    end
  end

  // Behavioural model: predicts the outputs that follow each rising edge
  bit              m_valid = 1'b0;
  logic [NREQ-1:0] e_gnt, e_ack;
  logic [6:0]      e_res;
  logic            e_err, e_st;
  logic [3:0]      e_mp, e_mc;
  int m_ptr, m_sync, m_k, m_age;
  bit m_job, m_drain;

  always @(posedge CLK) begin
    cyc++;
    if (!RST_N) begin
      m_valid = 1'b1;
      e_gnt = '0; e_ack = '0; e_res = '0; e_err = 1'b0; e_st = 1'b0; e_mp = '0; e_mc = '0;
      m_ptr = 0; m_sync = SYNC; m_job = 1'b0; m_drain = 1'b0; m_age = 0; m_k = 0;
    end else if (m_valid) begin
      e_ack = '0; e_err = 1'b0; e_st = 1'b0;
      if (m_sync > 0) begin
        m_sync--;
      end else if (m_drain) begin
        if (!Mul_Done) m_drain = 1'b0;
      end else if (!m_job) begin
        if (Req != '0) begin
          for (int i = NREQ - 1; i >= 0; i--) begin
            if (Req[(m_ptr + i) % NREQ]) m_k = (m_ptr + i) % NREQ;
          end
          e_gnt = '0;
          e_gnt[m_k] = 1'b1;
          e_mp = Mplier_in[4*m_k +: 4];
          e_mc = Mcand_in[4*m_k +: 4];
          m_job = 1'b1;
          m_age = 0;
        end
      end else if (m_age == 0) begin
        e_st = 1'b1;
        m_age = 1;
      end else if (Mul_Done || (m_age - 1 == WDOG)) begin
        e_res = Mul_Done ? Mul_Product : 7'd0;
        e_err = !Mul_Done;
        e_ack = '0;
        e_ack[m_k] = 1'b1;
        e_gnt = '0;
        m_ptr = (m_k + 1) % NREQ;
        m_job = 1'b0;
        m_drain = 1'b1;
      end else begin
        m_age++;
      end
    end
  end

  // Per-cycle compare against the model, plus event monitors for directed checks
  int ack_count = 0, st_count = 0;
  int ack_cyc = 0, st_cyc = 0, done_rise = 0;
  logic [NREQ-1:0] last_ack;
  logic [6:0] last_res;
  logic last_err;
  logic prev_done = 1'b0;
  logic [NREQ-1:0] prev_gnt = '0;
  int gnt_log[$];

  always @(negedge CLK) begin
    if (m_valid) begin
      check("gnt", 32'(Gnt), 32'(e_gnt));
      check("ack", 32'(Ack), 32'(e_ack));
      check("err", 32'(Err), 32'(e_err));
      check("mul_st", 32'(Mul_St), 32'(e_st));
      check("mul_mplier", 32'(Mul_Mplier), 32'(e_mp));
      check("mul_mcand", 32'(Mul_Mcand), 32'(e_mc));
      if (e_ack != '0) check("result", 32'(Result), 32'(e_res));
    end
    if (Ack != '0) begin
      ack_count++; last_ack = Ack; last_res = Result; last_err = Err; ack_cyc = cyc;
    end
    if (Mul_St) begin
      st_count++; st_cyc = cyc;
    end
    if (Mul_Done && !prev_done) done_rise = cyc;
    prev_done = Mul_Done;
    if (Gnt != '0 && prev_gnt == '0) begin
      for (int i = 0; i < NREQ; i++) if (Gnt[i]) gnt_log.push_back(i);
    end
    prev_gnt = Gnt;
  end

  task automatic cycles(input int n);
    repeat (n) @(posedge CLK);
    #1;
  endtask

  task automatic wait_st(input int n0, input string nm);
    int t = 0;
    while (st_count == n0 && t < 200) begin @(negedge CLK); #1; t++; end
    if (st_count == n0) begin
      checks++; errors++;
      $display("FAIL %s: got no Mul_St within 200 cycles, expected one", nm);
    end
  endtask

  task automatic wait_ack(input int n0, input string nm);
    int t = 0;
    while (ack_count == n0 && t < 200) begin @(negedge CLK); #1; t++; end
    if (ack_count == n0) begin
      checks++; errors++;
      $display("FAIL %s: got no Ack within 200 cycles, expected one", nm);
    end
  endtask

  int n_st, n_ack, t0, x, a1;
  int exp_order[5];

  initial begin
    RST_N = 1'b0; Req = '0; Mplier_in = '0; Mcand_in = '0;
    @(posedge CLK); @(negedge CLK);
    check("reset_outputs", 32'({Gnt, Ack, Result, Err, Mul_St, Mul_Mplier, Mul_Mcand}), 32'd0);
    @(posedge CLK); #1; RST_N = 1'b1;
    cycles(SYNC + 3);

    // 0.5 * 0.5 from requester 1
    n_st = st_count; n_ack = ack_count; t0 = cyc;
    Req = 4'b0010; Mplier_in[7:4] = 4'b0100; Mcand_in[7:4] = 4'b0100;
    wait_st(n_st, "t1_st");
    check("t1_st_latency", 32'(st_cyc - t0), 32'd2);
    wait_ack(n_ack, "t1_ack");
    check("t1_ack_vec", 32'(last_ack), 32'b0010);
    check("t1_result", 32'(last_res), 32'h10);
    check("t1_err", 32'(last_err), 32'd0);
    check("t1_done_to_ack", 32'(ack_cyc - done_rise), 32'd1);
    @(posedge CLK); #1; Req = '0;

    // -0.5 * 0.5 from requester 2
    cycles(2);
    n_ack = ack_count;
    Req = 4'b0100; Mplier_in[11:8] = 4'b1100; Mcand_in[11:8] = 4'b0100;
    wait_ack(n_ack, "t2_ack");
    check("t2_ack_vec", 32'(last_ack), 32'b0100);
    check("t2_result", 32'(last_res), 32'h70);
    @(posedge CLK); #1; Req = '0;

    // Fairness with all requesters active, starting from a fresh pointer
    cycles(2);
    gnt_log.delete();
    RST_N = 1'b0; Req = 4'b1111;
    @(posedge CLK); #1; RST_N = 1'b1;
    n_ack = ack_count;
    for (int i = 0; i < 5; i++) wait_ack(n_ack + i, "t3_ack");
    @(posedge CLK); #1; Req = '0;
    exp_order = '{0, 1, 2, 3, 0};
    check("t3_grant_count", 32'(gnt_log.size()), 32'd5);
    for (int i = 0; i < 5; i++) begin
      if (i < gnt_log.size()) check("t3_grant_order", 32'(gnt_log[i]), 32'(exp_order[i]));
    end

    // Watchdog: multiplier never answers
    cycles(2);
    stub_never = 1'b1;
    n_st = st_count; n_ack = ack_count;
    Req = 4'b0001;
    wait_st(n_st, "t4_st");
    t0 = st_cyc;
    wait_ack(n_ack, "t4_ack");
    check("t4_wdog_delay", 32'(ack_cyc - t0), 32'(WDOG + 1));
    check("t4_ack_vec", 32'(last_ack), 32'b0001);
    check("t4_err", 32'(last_err), 32'd1);
    check("t4_result", 32'(last_res), 32'd0);
    @(posedge CLK); #1; Req = '0; stub_never = 1'b0;

    // Stale Done held four cycles must not complete the next job
    cycles(2);
    stub_len = 4;
    n_ack = ack_count;
    Req = 4'b0100; Mplier_in[11:8] = 4'b0010; Mcand_in[11:8] = 4'b0010;
    wait_ack(n_ack, "t5_ack1");
    check("t5_result1", 32'(last_res), 32'h04);
    a1 = ack_cyc; n_ack = ack_count; n_st = st_count;
    @(posedge CLK); #1;
    Req = 4'b1000; Mplier_in[15:12] = 4'b0011; Mcand_in[15:12] = 4'b0010;
    wait_st(n_st, "t5_st2");
    check("t5_ack_to_st", 32'(st_cyc - a1), 32'd6);
    check("t5_single_ack", 32'(ack_count), 32'(n_ack));
    wait_ack(n_ack, "t5_ack2");
    check("t5_ack2_vec", 32'(last_ack), 32'b1000);
    check("t5_result2", 32'(last_res), 32'h06);
    check("t5_new_done", 32'(ack_cyc - done_rise), 32'd1);
    @(posedge CLK); #1; Req = '0; stub_len = 1;

    // Reset while waiting on the multiplier
    cycles(4);
    stub_never = 1'b1;
    n_st = st_count;
    Req = 4'b1000; Mplier_in[15:12] = 4'b0111; Mcand_in[15:12] = 4'b1000;
    wait_st(n_st, "t6_st_pre");
    cycles(3);
    RST_N = 1'b0; x = cyc;
    @(posedge CLK); #1; RST_N = 1'b1; stub_never = 1'b0;
    n_st = st_count; n_ack = ack_count;
    @(negedge CLK);
    check("t6_reset_outputs", 32'({Gnt, Ack, Result, Err, Mul_St, Mul_Mplier, Mul_Mcand}), 32'd0);
    wait_st(n_st, "t6_st_post");
    check("t6_sync_quiet", 32'(st_cyc - (x + 1)), 32'(SYNC + 2));
    check("t6_regrant", 32'(Gnt), 32'b1000);
    wait_ack(n_ack, "t6_ack");
    check("t6_ack_vec", 32'(last_ack), 32'b1000);
    check("t6_result", 32'(last_res), 32'h48);
    @(posedge CLK); #1; Req = '0;
    cycles(4);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
